// File: rtl/uart_cmd_frame_tx.sv
// Host-side command serializer: expands one command into its header/argument
// byte sequence and shifts each byte out as a UART frame at a latched prescale.
module uart_cmd_frame_tx #(
  parameter int GAP_BITS   = 1,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_type_i,
  input  logic [7:0]            arg0_i,
  input  logic [7:0]            arg1_i,
  input  logic [7:0]            arg2_i,
  input  logic                  par_en_i,
  input  logic                  par_typ_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tx_out_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  typedef struct packed {
    logic [1:0]            typ;
    logic [7:0]            a0;
    logic [7:0]            a1;
    logic [7:0]            a2;
    logic                  par_en;
    logic                  par_typ;
    logic [PRESCALE_W-1:0] ps;
  } cmd_t;

  localparam logic [PRESCALE_W-1:0] PS_MIN = PRESCALE_W'(4);
  localparam logic [2:0]            GAP_LAST = 3'(GAP_BITS - 1);

  state_t                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [1:0]            byte_q, byte_d;
  logic [2:0]            gap_q, gap_d;
  logic                  done_q, done_d;
  logic                  tx_q, tx_d;
  logic                  bit_end;
  logic [7:0]            cur_d;

  // Byte idx of a command: 0 is the opcode header, then the arguments in order.
  function automatic logic [7:0] byte_sel(input cmd_t c, input logic [1:0] idx);
    logic [7:0] b;
    b = c.a2;
    if (idx == 2'd0) begin
      case (c.typ)
        2'd0:    b = 8'hAA;
        2'd1:    b = 8'hBB;
        2'd2:    b = 8'hCC;
        default: b = 8'hDD;
      endcase
    end else if (c.typ == 2'd3) begin
      b = c.a2;
    end else begin
      case (idx)
        2'd1:    b = c.a0;
        2'd2:    b = c.a1;
        default: b = c.a2;
      endcase
    end
    return b;
  endfunction

  function automatic logic [1:0] last_byte(input logic [1:0] typ);
    logic [1:0] n;
    case (typ)
      2'd0:    n = 2'd2;
      2'd2:    n = 2'd3;
      default: n = 2'd1;
    endcase
    return n;
  endfunction

  assign bit_end = (cnt_q == cmd_q.ps - PRESCALE_W'(1));

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    if (state_q != S_IDLE)
      cnt_d = bit_end ? '0 : cnt_q + PRESCALE_W'(1);
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d        = S_START;
          cmd_d.typ      = cmd_type_i;
          cmd_d.a0       = arg0_i;
          cmd_d.a1       = arg1_i;
          cmd_d.a2       = arg2_i;
          cmd_d.par_en   = par_en_i;
          cmd_d.par_typ  = par_typ_i;
          cmd_d.ps       = (prescale_i < PS_MIN) ? PS_MIN : prescale_i;
          cnt_d          = '0;
          bit_d          = '0;
          byte_d         = '0;
          gap_d          = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) state_d = cmd_q.par_en ? S_PARITY : S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (byte_q == last_byte(cmd_q.typ)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            byte_d  = byte_q + 2'd1;
            gap_d   = '0;
            state_d = (GAP_BITS == 0) ? S_START : S_GAP;
          end
        end
      end
      S_GAP: begin
        if (bit_end) begin
          if (gap_q == GAP_LAST) begin
            state_d = S_START;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is registered from next-state so TX only moves on bit edges.
  always_comb begin
    cur_d = byte_sel(cmd_d, byte_d);
    tx_d  = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = cur_d[bit_d];
      S_PARITY: tx_d = (^cur_d) ^ cmd_d.par_typ;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign tx_out_o    = tx_q;

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// Directed + randomized bench for uart_cmd_frame_tx; two builds (gap 1 and gap 0)
// are checked cycle by cycle against a per-cycle line-level model.
module tb_uart_cmd_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid1, valid0;
  logic [1:0] typ;
  logic [7:0] a0, a1, a2;
  logic       pe, pt;
  logic [5:0] ps;
  logic       tx1, busy1, rdy1, done1;
  logic       tx0, busy0, rdy0, done0;

  int checks   = 0;
  int failures = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_cmd_frame_tx #(.GAP_BITS(1), .PRESCALE_W(6)) dut_g1 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(valid1), .cmd_ready_o(rdy1),
    .cmd_type_i(typ), .arg0_i(a0), .arg1_i(a1), .arg2_i(a2),
    .par_en_i(pe), .par_typ_i(pt), .prescale_i(ps),
    .tx_out_o(tx1), .busy_o(busy1), .done_o(done1)
  );

  uart_cmd_frame_tx #(.GAP_BITS(0), .PRESCALE_W(6)) dut_g0 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(valid0), .cmd_ready_o(rdy0),
    .cmd_type_i(typ), .arg0_i(a0), .arg1_i(a1), .arg2_i(a2),
    .par_en_i(pe), .par_typ_i(pt), .prescale_i(ps),
    .tx_out_o(tx0), .busy_o(busy0), .done_o(done0)
  );

  // {tx, busy, ready, done} of the selected build (0: gap 1, 1: gap 0)
  function automatic logic [3:0] obs(input bit sel);
    return sel ? {tx0, busy0, rdy0, done0} : {tx1, busy1, rdy1, done1};
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (tx,busy,ready,done)", tag, got, exp);
    end
  endtask

  // Expected TX level for every cycle of a command, straight from the frame rules.
  task automatic build(input logic [1:0] t, input logic [7:0] x0, input logic [7:0] x1,
                       input logic [7:0] x2, input logic en, input logic odd,
                       input logic [5:0] pres, input int gap);
    logic [7:0] bytes[$];
    logic       bits[$];
    int         p;
    p = (pres < 6'd4) ? 4 : int'(pres);
    case (t)
      2'd0: bytes = '{8'hAA, x0, x1};
      2'd1: bytes = '{8'hBB, x0};
      2'd2: bytes = '{8'hCC, x0, x1, x2};
      default: bytes = '{8'hDD, x2};
    endcase
    exp_q.delete();
    foreach (bytes[i]) begin
      bits.delete();
      if (i > 0) for (int g = 0; g < gap; g++) bits.push_back(1'b1);
      bits.push_back(1'b0);
      for (int b = 0; b < 8; b++) bits.push_back(bytes[i][b]);
      if (en) bits.push_back((^bytes[i]) ^ odd);
      bits.push_back(1'b1);
      foreach (bits[k]) for (int c = 0; c < p; c++) exp_q.push_back(bits[k]);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first idle cycle after DONE.
  task automatic run_cmd(input bit sel, input logic [1:0] t, input logic [7:0] x0,
                         input logic [7:0] x1, input logic [7:0] x2, input logic en,
                         input logic odd, input logic [5:0] pres, input bit hold);
    build(t, x0, x1, x2, en, odd, pres, sel ? 0 : 1);
    typ = t; a0 = x0; a1 = x1; a2 = x2; pe = en; pt = odd; ps = pres;
    if (sel) valid0 = 1'b1; else valid1 = 1'b1;
    chk("ready_before_accept", {3'b000, obs(sel)[1]}, 4'b0001);
    @(posedge clk);
    #1;
    if (!hold) begin
      valid0 = 1'b0; valid1 = 1'b0;
    end
    // Input churn during the command must not leak into the frame.
    typ = 2'($urandom); a0 = 8'($urandom); a1 = 8'($urandom); a2 = 8'($urandom);
    pe = 1'($urandom); pt = 1'($urandom); ps = 6'($urandom);
    foreach (exp_q[k]) begin
      @(negedge clk);
      chk($sformatf("line_cyc%0d", k + 1), obs(sel), {exp_q[k], 1'b1, 1'b0, 1'b0});
    end
    @(negedge clk);
    chk("done_first_idle", obs(sel), 4'b1011);
  endtask

  task automatic idle_check(input bit sel);
    @(negedge clk);
    chk("idle", obs(sel), 4'b1010);
  endtask

  initial begin
    bit   sel, hold, prev_hold;
    logic [5:0] pr;
    rst = 1'b1; valid1 = 1'b0; valid0 = 1'b0;
    typ = '0; a0 = '0; a1 = '0; a2 = '0; pe = 1'b0; pt = 1'b0; ps = 6'd16;
    #2;
    chk("reset_g1", obs(0), 4'b1010);
    chk("reset_g0", obs(1), 4'b1010);
    @(negedge clk);
    rst = 1'b0;
    idle_check(0);

    run_cmd(0, 2'd0, 8'h05, 8'h3C, 8'h00, 1'b0, 1'b0, 6'd16, 0);
    idle_check(0);
    run_cmd(0, 2'd1, 8'h07, 8'h00, 8'h00, 1'b1, 1'b0, 6'd16, 0);
    run_cmd(0, 2'd1, 8'h07, 8'h00, 8'h00, 1'b1, 1'b1, 6'd16, 0);
    run_cmd(0, 2'd2, 8'h12, 8'h34, 8'h01, 1'b0, 1'b0, 6'd8, 1);
    run_cmd(0, 2'd3, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 6'd8, 0);
    idle_check(0);
    run_cmd(0, 2'd1, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0, 6'd32, 0);
    run_cmd(0, 2'd0, 8'hC3, 8'h81, 8'h00, 1'b1, 1'b1, 6'd2, 0);

    // Abort in the data bits of byte 2 (P=8: byte 2 data spans cycles 97-160).
    typ = 2'd0; a0 = 8'hFF; a1 = 8'h00; pe = 1'b0; ps = 6'd8; valid1 = 1'b1;
    @(posedge clk);
    #1 valid1 = 1'b0;
    repeat (110) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset_mid_frame", obs(0), 4'b1010);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) idle_check(0);
    run_cmd(0, 2'd0, 8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 6'd8, 0);

    run_cmd(1, 2'd3, 8'h00, 8'h00, 8'h0A, 1'b0, 1'b0, 6'd8, 0);
    idle_check(1);

    prev_hold = 1'b0;
    sel = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (!prev_hold) sel = 1'($urandom);
      hold = (i < 13) && ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: pr = 6'd8;
        1: pr = 6'd16;
        2: pr = 6'd32;
        default: pr = 6'($urandom_range(0, 7));
      endcase
      run_cmd(sel, 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom), 1'($urandom), pr, hold);
      prev_hold = hold;
    end
    idle_check(sel);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_frame_tx.md
Name: uart_cmd_frame_tx

Overview:
Host-side command serializer that sits directly upstream of the system's RX_IN pin. It accepts one register-write, register-read, ALU-with-operands or ALU-no-operand command per handshake. It expands the command into the multi-byte frame sequence the system controller decodes, then transmits each byte as a UART frame (start, 8 data bits LSB first, optional parity, stop) at a runtime-selected prescale. It is used as the stimulus master in system benches and as the front end of the host bridge.

Parameters:
GAP_BITS, 1, idle-high bit periods inserted between consecutive bytes of one command (0 to 7)
PRESCALE_W, 6, width of the PRESCALE port

Ports:
CLK  in  1  oversampling clock; one UART bit lasts PRESCALE cycles of CLK
RST  in  1  asynchronous, active-high reset
CMD_VALID  in  1  command request
CMD_READY  out  1  block idle and able to accept
CMD_TYPE  in  2  0=REG_WR(0xAA), 1=REG_RD(0xBB), 2=ALU_OP(0xCC), 3=ALU_NOP(0xDD)
ARG0  in  8  register address (REG_WR/REG_RD), operand A (ALU_OP)
ARG1  in  8  write data (REG_WR), operand B (ALU_OP)
ARG2  in  8  ALU function code (ALU_OP/ALU_NOP)
PAR_EN  in  1  1 = append parity bit
PAR_TYP  in  1  0 = even, 1 = odd
PRESCALE  in  6  cycles per bit; legal 8/16/32; values below 4 are treated as 4
TX_OUT  out  1  serial line, idle high
BUSY  out  1  high from the cycle after accept until the last stop bit completes
DONE  out  1  one-cycle pulse when a command's final stop bit completes

Behaviour:
- Reset (async, any state): TX_OUT=1, CMD_READY=1, BUSY=0, DONE=0, FSM=IDLE, all counters 0. A reset mid-frame aborts the frame immediately. It produces no DONE, and the partial frame is not resumed.
- Accept: a command is accepted at a CLK edge with CMD_VALID&&CMD_READY. The edge captures CMD_TYPE, ARG0..2, PAR_EN, PAR_TYP and PRESCALE (clamped) into holding registers. Input changes during a command are ignored.
- Byte sequence:
  - REG_WR: AA, ARG0, ARG1 (3 bytes)
  - REG_RD: BB, ARG0 (2 bytes)
  - ALU_OP: CC, ARG0, ARG1, ARG2 (4 bytes)
  - ALU_NOP: DD, ARG2 (2 bytes)
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
  - IDLE->START on accept.
  - START->DATA after one bit period.
  - DATA stays in DATA for 8 bit periods, bit index 0..7, LSB first.
  - DATA->PARITY if captured PAR_EN, else DATA->STOP.
  - PARITY->STOP.
  - STOP->GAP if more bytes remain and GAP_BITS>0.
  - STOP->START if more bytes remain and GAP_BITS=0.
  - STOP->IDLE after the last byte.
  - GAP->START after GAP_BITS bit periods.
- Bit timing: TX_OUT changes only on bit boundaries. The start bit is driven from the cycle after accept and each bit holds exactly PRESCALE cycles. The bit counter compares count == PRESCALE-1 and wraps to 0.
- Line levels: start=0, stop=1, gap=1.
- Parity: XOR of the 8 data bits, inverted when PAR_TYP=1. It is computed per byte from the byte being sent.
- Command length in CLK cycles: N·B·P + (N-1)·GAP_BITS·P, where N=bytes, B=10 (11 with parity), P=PRESCALE.
- DONE and CMD_READY both assert in the first IDLE cycle after the last stop bit. BUSY falls in that same cycle.
- Back-to-back commands: a CMD_VALID held high is accepted in that first IDLE cycle. The next start bit follows one cycle later, so the minimum inter-command idle is 1 cycle of TX_OUT=1.
- CMD_READY=0 in every non-IDLE state; requests are held off without loss.

Test Plan:
1. PRESCALE=16, PAR_EN=0, GAP_BITS=1, REG_WR ARG0=0x05 ARG1=0x3C accepted at cycle 0 -> TX_OUT low cycles 1-16, then bits of 0xAA LSB first. Bytes AA,05,3C each sent as 10 bits with one 16-cycle idle gap between bytes. DONE pulses at cycle 513 only, and CMD_READY returns at cycle 513.
2. PRESCALE=16, PAR_EN=1, PAR_TYP=0, REG_RD ARG0=0x07 -> parity bit 0 for 0xBB and 1 for 0x07. Repeat with PAR_TYP=1 -> parity bits 1 and 0. Each byte occupies 11·16 cycles.
3. PRESCALE=8, ALU_OP ARG0=0x12 ARG1=0x34 ARG2=0x01, CMD_VALID held high with ALU_NOP queued behind it -> bytes CC,12,34,01 are sent, DONE pulses, and the next command is accepted the same cycle. DD,01 starts one cycle later, with no lost or duplicated command.
4. PRESCALE=32 at accept, then PRESCALE changed to 8 and ARG0 changed mid-frame -> the frame keeps 32-cycle bits and the original ARG0. PRESCALE=2 -> bits last 4 cycles.
5. RST asserted during the DATA state of byte 2 -> TX_OUT=1, BUSY=0 and CMD_READY=1 asynchronously, with no DONE. A new command afterwards transmits from its first byte cleanly.
6. GAP_BITS=0 build, ALU_NOP ARG2=0x0A -> the stop bit of 0xDD is immediately followed by the start bit of 0x0A. Total length is 2·10·P cycles.
